// File: rtl/neuron_learn_layer_seq.sv
// Time-multiplexed learning layer: M neurons x N inputs share one MAC, with optional delta-rule update.
// Define NEURON_LAYER_MINMAX_EN to build per-neuron activation max/min tracking.
module neuron_learn_layer_seq #(
  parameter int N        = 16,
  parameter int M        = 20,
  parameter int DW       = 8,
  parameter int WW       = 16,
  parameter int WF       = 12,
  parameter int LR_SHIFT = 4,
  parameter int W_INIT   = 4096
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   learn,
  input  logic [N*DW-1:0]        in,
  input  logic [M*DW-1:0]        expected_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [M*DW-1:0]        out,
  output logic [N*DW-1:0]        expected_in,
  output logic [M*N*WW-1:0]      weights,
  output logic [M*WW-1:0]        activation_max,
  output logic [M*WW-1:0]        activation_min,
  input  logic                   wr_en,
  input  logic [$clog2(M)-1:0]   wr_m,
  input  logic [$clog2(N)-1:0]   wr_n,
  input  logic [WW-1:0]          wr_data
);
  localparam int NW = $clog2(N);
  localparam int MW = $clog2(M);
  localparam int AW = DW + WW + $clog2(N) + 1;
  localparam int PW = DW + 1 + WW;
  localparam int EW = DW + 1;
  localparam int UW = 2 * DW + 1;
  localparam int SW = ((WW > UW) ? WW : UW) + 1;
  localparam int BW = PW + $clog2(M) + 1;
  localparam int SH = 2 * DW + LR_SHIFT - WF;
  localparam logic signed [BW-1:0] M_DIV = BW'(M);
  localparam logic signed [WW-1:0] W_MAX = {1'b0, {(WW-1){1'b1}}};
  localparam logic signed [WW-1:0] W_MIN = {1'b1, {(WW-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_MAC, S_ACT, S_UPD, S_BP, S_DONE} state_t;

  state_t state, state_nx;
  logic [MW-1:0] m_idx, m_nx;
  logic [NW-1:0] n_idx, n_nx;
  logic last_n, last_m, learn_q;

  logic signed [WW-1:0] w [M][N];
  logic [DW-1:0] in_q [N];
  logic [DW-1:0] exp_q [M];
  logic [DW-1:0] out_q [M];
  logic [DW-1:0] exp_in_q [N];
  logic signed [EW-1:0] err [M];
  logic signed [BW-1:0] bp [N];
  logic signed [AW-1:0] acc;

  logic signed [WW-1:0] cur_w;
  logic [DW-1:0] cur_in;
  logic signed [EW-1:0] cur_err, err_new;
  logic signed [PW-1:0] in_ext, w_ext, mac_prod, bp_prod;
  logic signed [AW-1:0] acc_base, acc_sum, acc_sh;
  logic [DW-1:0] mac_clamp;
  logic signed [UW-1:0] err_u, in_u, upd_prod, delta;
  logic signed [SW-1:0] w_sum;
  logic signed [WW-1:0] w_new;
  logic signed [BW-1:0] bp_base, bp_sum, bp_q, bp_s, bp_tot;
  logic [DW-1:0] bp_clamp [N];

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = S_MAC;
      end
      S_MAC:  if (last_n && last_m) state_nx = S_ACT;
      S_ACT:  state_nx = learn_q ? S_UPD : S_DONE;
      S_UPD:  if (last_n && last_m) state_nx = S_BP;
      S_BP:   state_nx = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    last_n = (n_idx == NW'(N - 1));
    last_m = (m_idx == MW'(M - 1));
    n_nx   = last_n ? '0 : n_idx + NW'(1);
    m_nx   = m_idx;
    if (last_n) m_nx = last_m ? '0 : m_idx + MW'(1);
  end

  // Shared datapath: one inference product or one weight/back-prop step per cycle.
  always_comb begin
    cur_w    = w[m_idx][n_idx];
    cur_in   = in_q[n_idx];
    cur_err  = err[m_idx];
    in_ext   = PW'($signed({1'b0, cur_in}));
    w_ext    = PW'(cur_w);
    mac_prod = in_ext * w_ext;
    acc_base = acc;
    if (n_idx == '0) acc_base = '0;
    acc_sum  = acc_base + AW'(mac_prod);
    acc_sh   = acc_sum >>> WF;
    if (acc_sh[AW-1])            mac_clamp = '0;
    else if (|acc_sh[AW-2:DW])   mac_clamp = '1;
    else                         mac_clamp = acc_sh[DW-1:0];
    err_new  = $signed({1'b0, exp_q[m_idx]}) - $signed({1'b0, mac_clamp});

    err_u    = UW'(cur_err);
    in_u     = UW'($signed({1'b0, cur_in}));
    upd_prod = err_u * in_u;
    delta    = upd_prod >>> SH;
    w_sum    = SW'(cur_w) + SW'(delta);
    if (w_sum[SW-1:WW-1] == '0 || w_sum[SW-1:WW-1] == '1) w_new = w_sum[WW-1:0];
    else                                                   w_new = w_sum[SW-1] ? W_MIN : W_MAX;
    bp_prod  = PW'(cur_err) * w_ext;
    bp_base  = bp[n_idx];
    if (m_idx == '0) bp_base = '0;
    bp_sum   = bp_base + BW'(bp_prod);
  end

  // Averaged back-propagated correction; division truncates toward zero before the fixed-point shift.
  always_comb begin
    bp_q   = '0;
    bp_s   = '0;
    bp_tot = '0;
    for (int k = 0; k < N; k++) begin
      bp_q   = bp[k] / M_DIV;
      bp_s   = bp_q >>> WF;
      bp_tot = bp_s + BW'($signed({1'b0, in_q[k]}));
      if (bp_tot[BW-1])          bp_clamp[k] = '0;
      else if (|bp_tot[BW-2:DW]) bp_clamp[k] = '1;
      else                       bp_clamp[k] = bp_tot[DW-1:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      m_idx   <= '0;
      n_idx   <= '0;
      acc     <= '0;
      learn_q <= 1'b0;
      for (int i = 0; i < M; i++) begin
        out_q[i] <= '0;
        err[i]   <= '0;
        exp_q[i] <= '0;
        for (int j = 0; j < N; j++) w[i][j] <= WW'(W_INIT);
      end
      for (int j = 0; j < N; j++) begin
        in_q[j]     <= '0;
        bp[j]       <= '0;
        exp_in_q[j] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          m_idx <= '0;
          n_idx <= '0;
          if (wr_en && (int'(wr_m) < M) && (int'(wr_n) < N)) w[wr_m][wr_n] <= wr_data;
          if (in_valid) begin
            learn_q <= learn;
            for (int j = 0; j < N; j++) in_q[j] <= in[j*DW +: DW];
            for (int i = 0; i < M; i++) exp_q[i] <= expected_out[i*DW +: DW];
          end
        end
        S_MAC: begin
          acc   <= acc_sum;
          m_idx <= m_nx;
          n_idx <= n_nx;
          if (last_n) begin
            out_q[m_idx] <= mac_clamp;
            err[m_idx]   <= err_new;
          end
        end
        S_UPD: begin
          bp[n_idx]          <= bp_sum;
          w[m_idx][n_idx]    <= w_new;
          m_idx              <= m_nx;
          n_idx              <= n_nx;
        end
        S_BP: begin
          for (int j = 0; j < N; j++) exp_in_q[j] <= bp_clamp[j];
        end
        default: ;
      endcase
    end
  end

  for (genvar gm = 0; gm < M; gm++) begin : g_row
    assign out[gm*DW +: DW] = out_q[gm];
    for (genvar gn = 0; gn < N; gn++) begin : g_col
      assign weights[(gm*N+gn)*WW +: WW] = w[gm][gn];
    end
  end

  for (genvar gn = 0; gn < N; gn++) begin : g_bp
    assign expected_in[gn*DW +: DW] = exp_in_q[gn];
  end

`ifdef NEURON_LAYER_MINMAX_EN
  logic signed [WW-1:0] mac_sat;
  logic signed [WW-1:0] act_sat [M];
  logic signed [WW-1:0] act_max [M];
  logic signed [WW-1:0] act_min [M];

  always_comb begin
    if (acc_sh[AW-1:WW-1] == '0 || acc_sh[AW-1:WW-1] == '1) mac_sat = acc_sh[WW-1:0];
    else                                                     mac_sat = acc_sh[AW-1] ? W_MIN : W_MAX;
  end

  // Each neuron's saturated activation is latched as it completes and folded into the extremes in ACT.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < M; i++) begin
        act_sat[i] <= '0;
        act_max[i] <= W_MIN;
        act_min[i] <= W_MAX;
      end
    end else begin
      if (state == S_MAC && last_n) act_sat[m_idx] <= mac_sat;
      if (state == S_ACT) begin
        for (int i = 0; i < M; i++) begin
          if (act_sat[i] > act_max[i]) act_max[i] <= act_sat[i];
          if (act_sat[i] < act_min[i]) act_min[i] <= act_sat[i];
        end
      end
    end
  end

  for (genvar gm = 0; gm < M; gm++) begin : g_mm
    assign activation_max[gm*WW +: WW] = act_max[gm];
    assign activation_min[gm*WW +: WW] = act_min[gm];
  end
`else
  assign activation_max = '0;
  assign activation_min = '0;
`endif

endmodule
